ct_ifu_icache_tag_ctrl: RTL

//  Requester-side sequencer for the I-cache tag SRAM wrapper: generates index/cen_b/clk_en/din/wen, consumes tag dout.

---
 rtl/ct_ifu_icache_tag_ctrl.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/ct_ifu_icache_tag_ctrl.sv
// ---------------------------------------------------------------------------
// ct_ifu_icache_tag_ctrl
//
// Requester-side sequencer for the I-cache tag SRAM wrapper. It arbitrates
// three clients and turns each accepted request into registered SRAM strobes:
//   - invalidate-all sweep from CP0 (writes zero to every set),
//   - refill tag write (one way's {vld,tag} plus the LRU bit),
//   - tag read for debug/ICC (strobe, then capture dout one cycle later).
// Priority is inv > refill > read. Grants are combinational and are only
// issued in IDLE.
//
// Tag word layout (59b): [58]=LRU, [57:29]=way1 {vld,tag}, [28:0]=way0 {vld,tag}
// Write enables are active-low per group: wen = {lru, way1, way0}.
//
// Ports
//   forever_cpuclk, cpurst_b          clock, synchronous active-low reset
//   cp0_ifu_inv_req / ifu_cp0_inv_gnt invalidate-all handshake
//   ifu_cp0_inv_done                  one-cycle pulse after the last sweep write
//   refill_tag_*                      refill write request/grant and payload
//   rd_tag_req/gnt/index              tag read request/grant and address
//   rd_tag_vld / rd_tag_data          read result pulse and held result word
//   ifu_icache_index/tag_*            registered SRAM-side strobe outputs
//   icache_ifu_tag_dout               SRAM read data (one cycle after strobe)
// ---------------------------------------------------------------------------
module ct_ifu_icache_tag_ctrl #(
    parameter int INDEX_MSB = 12,
    parameter int SET_NUM   = 2 ** (INDEX_MSB - 4)
) (
    input  logic        forever_cpuclk,
    input  logic        cpurst_b,
    input  logic        cp0_ifu_inv_req,
    output logic        ifu_cp0_inv_gnt,
    output logic        ifu_cp0_inv_done,
    input  logic        refill_tag_req,
    output logic        refill_tag_gnt,
    input  logic [15:0] refill_tag_index,
    input  logic        refill_tag_way,
    input  logic [27:0] refill_tag_value,
    input  logic        refill_tag_lru,
    input  logic        rd_tag_req,
    output logic        rd_tag_gnt,
    input  logic [15:0] rd_tag_index,
    output logic        rd_tag_vld,
    output logic [58:0] rd_tag_data,
    output logic [15:0] ifu_icache_index,
    output logic        ifu_icache_tag_cen_b,
    output logic        ifu_icache_tag_clk_en,
    output logic [58:0] ifu_icache_tag_din,
    output logic [2:0]  ifu_icache_tag_wen,
    input  logic [58:0] icache_ifu_tag_dout
);

    localparam int               SET_W    = INDEX_MSB - 4;
    localparam logic [SET_W-1:0] LAST_SET = SET_W'(SET_NUM - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INV    = 3'd1,
        WR     = 3'd2,
        RD_STB = 3'd3,
        RD_DAT = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [SET_W-1:0] cnt;
    logic [SET_W-1:0] cnt_nxt;

    logic             cen_b_nxt;
    logic [2:0]       wen_nxt;
    logic [15:0]      index_nxt;
    logic [58:0]      din_nxt;
    logic             done_nxt;
    logic             vld_nxt;
    logic             capture;
    logic             idle;

    // Only the set-address bits of the client indices reach the SRAM.
    logic unused_index_bits;
    assign unused_index_bits = ^{refill_tag_index[15:INDEX_MSB+1], refill_tag_index[4:0],
                                 rd_tag_index[15:INDEX_MSB+1], rd_tag_index[4:0]};

    // Place a set address at index[INDEX_MSB:5], all other bits zero.
    function automatic logic [15:0] set_to_index(input logic [SET_W-1:0] set);
        return 16'(set) << 5;
    endfunction

    // State register
    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic. In INV, cnt is the set whose write is on the SRAM
    // pins during the current cycle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (ifu_cp0_inv_gnt) begin
                    state_nxt = INV;
                    cnt_nxt   = '0;
                end else if (refill_tag_gnt) begin
                    state_nxt = WR;
                end else if (rd_tag_gnt) begin
                    state_nxt = RD_STB;
                end
            end
            INV: begin
                if (cnt == LAST_SET) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            WR:      state_nxt = IDLE;
            RD_STB:  state_nxt = RD_DAT;
            RD_DAT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: combinational grants plus the next values of the
    // registered SRAM-side outputs. Strobes are launched one cycle ahead so
    // that the pins are driven straight from flops.
    always_comb begin
        idle            = (state == IDLE) && cpurst_b;
        ifu_cp0_inv_gnt = idle && cp0_ifu_inv_req;
        refill_tag_gnt  = idle && refill_tag_req && !cp0_ifu_inv_req;
        rd_tag_gnt      = idle && rd_tag_req && !cp0_ifu_inv_req && !refill_tag_req;

        cen_b_nxt = 1'b1;
        wen_nxt   = 3'b111;
        index_nxt = ifu_icache_index;
        din_nxt   = ifu_icache_tag_din;
        done_nxt  = 1'b0;
        vld_nxt   = 1'b0;
        capture   = 1'b0;

        case (state)
            IDLE: begin
                if (ifu_cp0_inv_gnt) begin
                    cen_b_nxt = 1'b0;
                    wen_nxt   = 3'b000;
                    index_nxt = set_to_index('0);
                    din_nxt   = '0;
                end else if (refill_tag_gnt) begin
                    cen_b_nxt = 1'b0;
                    // LRU always written; only the selected way's group enabled.
                    wen_nxt   = refill_tag_way ? 3'b001 : 3'b010;
                    index_nxt = set_to_index(refill_tag_index[INDEX_MSB:5]);
                    din_nxt   = {refill_tag_lru, 1'b1, refill_tag_value, 1'b1, refill_tag_value};
                end else if (rd_tag_gnt) begin
                    cen_b_nxt = 1'b0;
                    index_nxt = set_to_index(rd_tag_index[INDEX_MSB:5]);
                end
            end
            INV: begin
                if (cnt == LAST_SET) begin
                    done_nxt = 1'b1;
                end else begin
                    cen_b_nxt = 1'b0;
                    wen_nxt   = 3'b000;
                    index_nxt = set_to_index(cnt + 1'b1);
                    din_nxt   = '0;
                end
            end
            RD_DAT: begin
                vld_nxt = 1'b1;
                capture = 1'b1;
            end
            default: ;
        endcase
    end

    // Registered outputs
    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            ifu_icache_tag_cen_b  <= 1'b1;
            ifu_icache_tag_clk_en <= 1'b0;
            ifu_icache_tag_wen    <= 3'b111;
            ifu_icache_index      <= '0;
            ifu_icache_tag_din    <= '0;
            ifu_cp0_inv_done      <= 1'b0;
            rd_tag_vld            <= 1'b0;
            rd_tag_data           <= '0;
        end else begin
            ifu_icache_tag_cen_b  <= cen_b_nxt;
            ifu_icache_tag_clk_en <= ~cen_b_nxt;
            ifu_icache_tag_wen    <= wen_nxt;
            ifu_icache_index      <= index_nxt;
            ifu_icache_tag_din    <= din_nxt;
            ifu_cp0_inv_done      <= done_nxt;
            rd_tag_vld            <= vld_nxt;
            if (capture) begin
                rd_tag_data <= icache_ifu_tag_dout;
            end
        end
    end

endmodule
